fft_butterfly_pipe: RTL
=======================

// Module: fft_butterfly_pipe
// PURPOSE
//  Pipelined radix-2 DIT butterfly for the fixed-point FFT path. It computes
//  X = A + W*B and Y = A - W*B on signed fixed-point complex samples.
//  The W*B product uses the shared fixed-point complex multiply; this block
//  adds pipelining, valid/ready flow control, rounding, optional /2 scaling
//  and saturation. Sits between the FFT sample/twiddle sequencer (upstream)
//  and the stage memory write-back (downstream).
// PARAMETERS
//  fractional_size  12            fractional bits of all operands (Q format)
//  operand_size     16            width of every input/output component
//  expansion_size   operand_size  extra bits of internal product/sum width
// PORTS
//  i_clk         in   1    clock, all logic rising-edge
//  i_reset       in   1    synchronous, active-high reset
//  i_valid       in   1    input beat valid
//  o_ready       out  1    block can accept a beat this cycle
//  i_a_real/imag in   OS   operand A, signed (OS = operand_size)
//  i_b_real/imag in   OS   operand B, signed
//  i_w_real/imag in   OS   twiddle W, signed
//  i_scale       in   1    1: halve X and Y (per-stage FFT scaling)
//  o_valid       out  1    output beat valid
//  i_ready       in   1    downstream accepts output
//  o_x_real/imag out  OS   X = A + W*B, rounded, saturated
//  o_y_real/imag out  OS   Y = A - W*B, rounded, saturated
//  o_sat         out  1    sticky: a saturation occurred since reset/clear
//  i_clear_sat   in   1    clears o_sat (set wins if same cycle)
// BEHAVIOUR
//  - Transfer occurs when valid & ready are both high on a clock edge.
//  - 3 register stages:
//      S1 = input capture (A, B, W, scale);
//      S2 = W*B product (OS+ES wide, already shifted by fractional_size),
//           A sign-extended to OS+ES, scale;
//      S3 = add/sub, round, scale, saturate -> output regs.
//  - Latency: 3 cycles from input transfer to o_valid when never stalled.
//    Throughput: 1 beat/cycle.
//  - Per-stage advance: stage k loads when stage k+1 is empty or advancing.
//    Bubbles collapse.
//  - o_ready = ~S1.valid | S1 advancing. It is purely a function of stage
//    valids and i_ready (no dependency on i_valid).
//  - Stalled stages hold data and valid bit-exact. No beat is lost or
//    duplicated; order is preserved.
//  - Sums X/Y computed at OS+ES+1 bits; no wrap internally.
//  - i_scale=1: add 1 (round half up), then arithmetic shift right by 1.
//    i_scale=0: no shift.
//  - Saturate each component to [-2^(OS-1), 2^(OS-1)-1].
//  - o_sat sets in the cycle S3 loads a beat whose X or Y component clipped.
//  - Reset: all valids 0, o_valid=0, o_sat=0, outputs 0.
//    Reset mid-operation discards all in-flight beats; o_ready=1 the cycle
//    after reset deasserts.
//  - Data regs need no reset except the output regs (so outputs read 0).
//  - o_x/o_y are registered and stable while o_valid & ~i_ready.
// STRUCTURE
//  - Shared package fft_pkg: typedef cplx_t {real, imag} of OS bits;
//    typedef cplx_wide_t of OS+ES bits; function sat_to_os(); Q-format
//    constants (Q_ONE = 1<<fractional_size).
//  - One sub-module, fft_pipe_ctrl: per-stage valid/advance logic,
//    parameterised by stage count. Used again by later FFT pipeline blocks.
//  - Product stage instantiates the existing fixed-point complex multiply.
// TESTING (Q4.12, 1.0 = 4096)
//  1. W=(4096,0) A=(1000,200) B=(500,-300) scale=0
//     -> X=(1500,-100) Y=(500,500), o_valid exactly 3 cycles after input.
//  2. W=(0,4096) A=(1000,200) B=(500,-300)
//     -> W*B=(300,500), X=(1300,700) Y=(700,-300).
//  3. W=(4096,0) A=(30000,0) B=(10000,0) scale=0 -> X.real=32767, o_sat=1.
//     Same with scale=1 -> X.real=20000, Y.real=10000, o_sat unchanged.
//     i_clear_sat then -> o_sat=0.
//  4. Rounding: A=(3,-3) B=0 scale=1 -> X=Y=(2,-1).
//     A=(-32768,0) B=(-32768,0) W=1 scale=0 -> X.real=-32768 with o_sat=1.
//  5. Backpressure: 6 back-to-back beats, i_ready low cycles 2..7
//     -> o_ready drops after 3 beats buffered. Outputs hold; all 6 delivered
//     in order once i_ready high, no duplicates.
//  6. Reset asserted with 3 beats in flight -> o_valid=0 next cycle,
//     none of those beats ever appear. Next input appears after 3 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared fixed-point FFT types, Q-format constants and saturation helper
//
// Purpose: common definitions for the fixed-point FFT datapath blocks.
//   FFT_FS / FFT_OS / FFT_ES : default fractional, operand and expansion widths
//   Q_ONE                    : 1.0 in the default Q format
//   cplx_t / cplx_wide_t     : complex sample at operand / internal width
//   sat_to_os()              : clip a signed value to an os-bit two's complement range
package fft_pkg;

  localparam int FFT_FS = 12;
  localparam int FFT_OS = 16;
  localparam int FFT_ES = FFT_OS;
  localparam int Q_ONE  = 1 << FFT_FS;

  // "real" is a keyword, so the members are named re/im.
  typedef struct packed {
    logic signed [FFT_OS-1:0] re;
    logic signed [FFT_OS-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [FFT_OS+FFT_ES-1:0] re;
    logic signed [FFT_OS+FFT_ES-1:0] im;
  } cplx_wide_t;

  function automatic logic signed [63:0] sat_to_os(input logic signed [63:0] v, input int os);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (os - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (os - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// rtl/fft_cmul.sv - combinational fixed-point complex multiply P = W*B
//
// Purpose: full-precision complex product, arithmetically shifted right by
// fractional_size (floor), delivered at product_size bits.
// Ports:
//   i_w_real/imag  in  OS  twiddle W, signed
//   i_b_real/imag  in  OS  operand B, signed
//   o_p_real/imag  out PS  W*B >>> fractional_size, signed
module fft_cmul import fft_pkg::*; #(
  parameter int operand_size    = FFT_OS,
  parameter int fractional_size = FFT_FS,
  parameter int product_size    = FFT_OS + FFT_ES
) (
  input  logic signed [operand_size-1:0] i_w_real,
  input  logic signed [operand_size-1:0] i_w_imag,
  input  logic signed [operand_size-1:0] i_b_real,
  input  logic signed [operand_size-1:0] i_b_imag,
  output logic signed [product_size-1:0] o_p_real,
  output logic signed [product_size-1:0] o_p_imag
);

  // One guard bit above the 2*OS product covers (-2^(OS-1))^2 + (-2^(OS-1))^2.
  localparam int MW = 2 * operand_size + 1;

  logic signed [MW-1:0] wr_x, wi_x, br_x, bi_x;
  logic signed [MW-1:0] sum_re, sum_im;

  always_comb begin
    wr_x   = MW'(i_w_real);
    wi_x   = MW'(i_w_imag);
    br_x   = MW'(i_b_real);
    bi_x   = MW'(i_b_imag);
    sum_re = wr_x * br_x - wi_x * bi_x;
    sum_im = wr_x * bi_x + wi_x * br_x;
  end

  assign o_p_real = product_size'(sum_re >>> fractional_size);
  assign o_p_imag = product_size'(sum_im >>> fractional_size);

endmodule

// File: rtl/fft_pipe_ctrl.sv
// rtl/fft_pipe_ctrl.sv - valid/ready control for a linear register pipeline
//
// Purpose: tracks one valid bit per stage and produces per-stage load enables.
// A stage loads when it is empty or its contents move on, so bubbles collapse.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_valid         upstream beat valid
//   o_ready         stage 0 can take a beat (independent of i_valid)
//   o_valid         last stage holds a beat
//   i_ready         downstream takes the last stage this cycle
//   o_load[n-1:0]   stage k captures new data this cycle
module fft_pipe_ctrl #(
  parameter int n_stages = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [n_stages-1:0] o_load
);

  logic [n_stages-1:0] valid_q, valid_d;
  logic [n_stages-1:0] rdy;

  // Ready ripples back from the output; a scalar carries it so the vector
  // never feeds itself inside the block.
  always_comb begin
    logic r;
    logic up;
    rdy     = '0;
    o_load  = '0;
    valid_d = valid_q;
    r = ~valid_q[n_stages-1] | i_ready;
    rdy[n_stages-1] = r;
    for (int k = n_stages - 2; k >= 0; k--) begin
      r = ~valid_q[k] | r;
      rdy[k] = r;
    end
    for (int k = 0; k < n_stages; k++) begin
      up = (k == 0) ? i_valid : valid_q[(k == 0) ? 0 : k - 1];
      o_load[k] = rdy[k] & up;
      if (rdy[k]) begin
        valid_d[k] = up;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign o_ready = rdy[0];
  assign o_valid = valid_q[n_stages-1];

endmodule

// File: rtl/fft_butterfly_pipe.sv
// rtl/fft_butterfly_pipe.sv - pipelined radix-2 DIT butterfly X=A+W*B, Y=A-W*B
//
// Purpose: three register stages (capture, product, add/round/saturate) with
// valid/ready flow control, optional /2 scaling and a sticky saturation flag.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_valid / o_ready     input handshake
//   i_a_*, i_b_*, i_w_*   operands A, B and twiddle W (signed, OS bits)
//   i_scale               1: X and Y are halved with round-half-up
//   o_valid / i_ready     output handshake
//   o_x_*, o_y_*          registered, saturated results
//   o_sat, i_clear_sat    sticky saturation flag and its clear (set wins)
module fft_butterfly_pipe import fft_pkg::*; #(
  parameter int fractional_size = FFT_FS,
  parameter int operand_size    = FFT_OS,
  parameter int expansion_size  = operand_size
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic signed [operand_size-1:0] i_a_real,
  input  logic signed [operand_size-1:0] i_a_imag,
  input  logic signed [operand_size-1:0] i_b_real,
  input  logic signed [operand_size-1:0] i_b_imag,
  input  logic signed [operand_size-1:0] i_w_real,
  input  logic signed [operand_size-1:0] i_w_imag,
  input  logic                           i_scale,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic signed [operand_size-1:0] o_x_real,
  output logic signed [operand_size-1:0] o_x_imag,
  output logic signed [operand_size-1:0] o_y_real,
  output logic signed [operand_size-1:0] o_y_imag,
  output logic                           o_sat,
  input  logic                           i_clear_sat
);

  localparam int OS = operand_size;
  localparam int PW = operand_size + expansion_size;
  // One bit for the add/sub, one more so the rounding increment cannot wrap.
  localparam int SW = PW + 2;

  logic [2:0] load;

  fft_pipe_ctrl #(.n_stages(3)) u_ctrl (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_load  (load)
  );

  // Stage 1: input capture
  logic signed [OS-1:0] s1_ar_q, s1_ai_q, s1_br_q, s1_bi_q, s1_wr_q, s1_wi_q;
  logic                 s1_sc_q;

  always_ff @(posedge i_clk) begin
    if (load[0]) begin
      s1_ar_q <= i_a_real;
      s1_ai_q <= i_a_imag;
      s1_br_q <= i_b_real;
      s1_bi_q <= i_b_imag;
      s1_wr_q <= i_w_real;
      s1_wi_q <= i_w_imag;
      s1_sc_q <= i_scale;
    end
  end

  // Stage 2: W*B product and widened A
  logic signed [PW-1:0] prod_re_d, prod_im_d;
  logic signed [PW-1:0] s2_ar_q, s2_ai_q, s2_pr_q, s2_pi_q;
  logic                 s2_sc_q;

  fft_cmul #(
    .operand_size    (OS),
    .fractional_size (fractional_size),
    .product_size    (PW)
  ) u_cmul (
    .i_w_real (s1_wr_q),
    .i_w_imag (s1_wi_q),
    .i_b_real (s1_br_q),
    .i_b_imag (s1_bi_q),
    .o_p_real (prod_re_d),
    .o_p_imag (prod_im_d)
  );

  always_ff @(posedge i_clk) begin
    if (load[1]) begin
      s2_ar_q <= PW'(s1_ar_q);
      s2_ai_q <= PW'(s1_ai_q);
      s2_pr_q <= prod_re_d;
      s2_pi_q <= prod_im_d;
      s2_sc_q <= s1_sc_q;
    end
  end

  // Stage 3: add/sub, round+scale, saturate.
  // Component order in the arrays: 0=X.re, 1=X.im, 2=Y.re, 3=Y.im.
  logic signed [SW-1:0] sum_d    [4];
  logic signed [SW-1:0] scaled_d [4];
  logic signed [63:0]   sat_d    [4];
  logic signed [OS-1:0] res_d    [4];
  logic                 clip_d;

  always_comb begin
    sum_d[0] = SW'(s2_ar_q) + SW'(s2_pr_q);
    sum_d[1] = SW'(s2_ai_q) + SW'(s2_pi_q);
    sum_d[2] = SW'(s2_ar_q) - SW'(s2_pr_q);
    sum_d[3] = SW'(s2_ai_q) - SW'(s2_pi_q);
    clip_d   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      // +1 before the arithmetic shift rounds exact halves toward +inf.
      scaled_d[k] = s2_sc_q ? ((sum_d[k] + SW'(1)) >>> 1) : sum_d[k];
      sat_d[k]    = sat_to_os(64'(scaled_d[k]), OS);
      res_d[k]    = OS'(sat_d[k]);
      clip_d      = clip_d | (sat_d[k] != 64'(scaled_d[k]));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_x_real <= '0;
      o_x_imag <= '0;
      o_y_real <= '0;
      o_y_imag <= '0;
      o_sat    <= 1'b0;
    end else begin
      if (load[2]) begin
        o_x_real <= res_d[0];
        o_x_imag <= res_d[1];
        o_y_real <= res_d[2];
        o_y_imag <= res_d[3];
      end
      if (load[2] && clip_d) begin
        o_sat <= 1'b1;
      end else if (i_clear_sat) begin
        o_sat <= 1'b0;
      end
    end
  end

endmodule
